// File: rtl/piece_collision_check_if.sv
// Request/result, shape-ROM and board-row bus between the game controller and the collision checker.
// The checker attaches through the slave modport; the controller side uses master.
interface piece_collision_check_if #(
  parameter int unsigned BOARD_W = 10,
  parameter int unsigned ROW_AW  = 5
);
  logic                start;
  logic [2:0]          piece;
  logic [1:0]          rot;
  logic signed [4:0]   pos_x;
  logic signed [5:0]   pos_y;
  logic [4:0]          shape_addr;
  logic [15:0]         shape_data;
  logic                board_rd_en;
  logic [ROW_AW-1:0]   board_row_addr;
  logic [BOARD_W-1:0]  board_row_data;
  logic                busy;
  logic                done;
  logic                collide;
  logic                oob;

  modport slave (
    input  start, piece, rot, pos_x, pos_y, shape_data, board_row_data,
    output shape_addr, board_rd_en, board_row_addr, busy, done, collide, oob
  );

  modport master (
    output start, piece, rot, pos_x, pos_y, shape_data, board_row_data,
    input  shape_addr, board_rd_en, board_row_addr, busy, done, collide, oob
  );
endinterface

// File: rtl/piece_collision_check.sv
// Fixed-latency tetromino placement checker: fetches the 4x4 shape mask, then scans
// its four rows against the board, flagging wall/floor violations and occupied cells.
module piece_collision_check #(
  parameter int unsigned BOARD_W = 10,
  parameter int unsigned BOARD_H = 20,
  parameter int unsigned ROW_AW  = 5
) (
  input logic                    Clk,
  input logic                    Reset_n,
  piece_collision_check_if.slave bus
);

  localparam int unsigned COL_W   = 6;
  localparam int unsigned ROW_W   = 7;
  localparam int unsigned SHAPE_W = 16;

  localparam logic signed [COL_W-1:0] board_w_s = COL_W'(BOARD_W);
  localparam logic signed [ROW_W-1:0] board_h_s = ROW_W'(BOARD_H);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ROW_REQ,
    S_ROW_CMP,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [2:0]          piece_q, piece_d;
  logic [1:0]          rot_q, rot_d;
  logic signed [4:0]   pos_x_q, pos_x_d;
  logic signed [5:0]   pos_y_q, pos_y_d;
  logic [SHAPE_W-1:0]  shape_q, shape_d;
  logic [1:0]          r_q, r_d;
  logic [4:0]          shape_addr_q, shape_addr_d;
  logic                rd_en_q, rd_en_d;
  logic [ROW_AW-1:0]   row_addr_q, row_addr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                collide_q, collide_d;
  logic                oob_q, oob_d;

  logic [1:0]              req_r;
  logic [SHAPE_W-1:0]      req_shape;
  logic signed [ROW_W-1:0] req_row;
  logic [3:0]              req_bits;
  logic signed [ROW_W-1:0] cur_row;
  logic [3:0]              cur_bits;
  logic signed [COL_W-1:0] col;

  // Bit c of the result is shape row r, column c (column 0 is the row nibble's MSB).
  function automatic logic [3:0] row_bits(input logic [SHAPE_W-1:0] shape, input logic [1:0] r);
    logic [3:0] nib;
    logic [3:0] m;
    nib = shape[15:12];
    case (r)
      2'd0:    nib = shape[15:12];
      2'd1:    nib = shape[11:8];
      2'd2:    nib = shape[7:4];
      default: nib = shape[3:0];
    endcase
    for (int c = 0; c < 4; c++) m[c] = nib[3-c];
    return m;
  endfunction

  function automatic logic signed [ROW_W-1:0] row_of(input logic signed [5:0] py, input logic [1:0] r);
    return ROW_W'(py) + $signed({5'b0, r});
  endfunction

  always_ff @(posedge Clk) begin
    if (!Reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (bus.start) state_d = S_FETCH;
      S_FETCH:   state_d = S_ROW_REQ;
      S_ROW_REQ: state_d = S_ROW_CMP;
      S_ROW_CMP: state_d = (r_q == 2'd3) ? S_DONE : S_ROW_REQ;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state, so board_rd_en is high exactly during ROW_REQ
  // and the row data arrives during ROW_CMP.
  always_comb begin
    piece_d      = piece_q;
    rot_d        = rot_q;
    pos_x_d      = pos_x_q;
    pos_y_d      = pos_y_q;
    shape_d      = shape_q;
    r_d          = r_q;
    shape_addr_d = shape_addr_q;
    row_addr_d   = row_addr_q;
    collide_d    = collide_q;
    oob_d        = oob_q;
    rd_en_d      = 1'b0;
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_q == S_DONE);
    req_r        = 2'd0;
    req_shape    = shape_q;
    cur_row      = row_of(pos_y_q, r_q);
    cur_bits     = row_bits(shape_q, r_q);
    col          = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          piece_d      = bus.piece;
          rot_d        = bus.rot;
          pos_x_d      = bus.pos_x;
          pos_y_d      = bus.pos_y;
          shape_addr_d = {bus.piece, bus.rot};
          collide_d    = 1'b0;
          oob_d        = 1'b0;
        end
      end
      S_FETCH: begin
        shape_d   = bus.shape_data;
        r_d       = 2'd0;
        req_shape = bus.shape_data;
      end
      S_ROW_CMP: begin
        // Rows above the board are spawn area and never collide.
        if (cur_row >= 7'sd0) begin
          for (int c = 0; c < 4; c++) begin
            if (cur_bits[c]) begin
              col = COL_W'(pos_x_q) + COL_W'(c);
              if (cur_row >= board_h_s || col < 6'sd0 || col >= board_w_s) begin
                collide_d = 1'b1;
                oob_d     = 1'b1;
              end else begin
                for (int j = 0; j < int'(BOARD_W); j++) begin
                  if (col == COL_W'(j) && bus.board_row_data[j]) collide_d = 1'b1;
                end
              end
            end
          end
        end
        if (r_q != 2'd3) begin
          r_d   = r_q + 2'd1;
          req_r = r_q + 2'd1;
        end
      end
      default: ;
    endcase

    req_row  = row_of(pos_y_q, req_r);
    req_bits = row_bits(req_shape, req_r);
    if (state_d == S_ROW_REQ && req_row >= 7'sd0 && req_row < board_h_s && (|req_bits)) begin
      rd_en_d    = 1'b1;
      row_addr_d = req_row[ROW_AW-1:0];
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      piece_q      <= '0;
      rot_q        <= '0;
      pos_x_q      <= '0;
      pos_y_q      <= '0;
      shape_q      <= '0;
      r_q          <= '0;
      shape_addr_q <= '0;
      rd_en_q      <= 1'b0;
      row_addr_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      collide_q    <= 1'b0;
      oob_q        <= 1'b0;
    end else begin
      piece_q      <= piece_d;
      rot_q        <= rot_d;
      pos_x_q      <= pos_x_d;
      pos_y_q      <= pos_y_d;
      shape_q      <= shape_d;
      r_q          <= r_d;
      shape_addr_q <= shape_addr_d;
      rd_en_q      <= rd_en_d;
      row_addr_q   <= row_addr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      collide_q    <= collide_d;
      oob_q        <= oob_d;
    end
  end

  assign bus.shape_addr     = shape_addr_q;
  assign bus.board_rd_en    = rd_en_q;
  assign bus.board_row_addr = row_addr_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.collide        = collide_q;
  assign bus.oob            = oob_q;

endmodule

// File: tb/tb_piece_collision_check.sv
// Directed bench for piece_collision_check: shape ROM and board row memory models,
// a vector table of placements, and hand sequences for re-pulsed start and mid-check reset.
module tb_piece_collision_check;

  logic Clk;
  logic Reset_n;

  piece_collision_check_if #(.BOARD_W(10), .ROW_AW(5)) bus ();

  piece_collision_check #(.BOARD_W(10), .BOARD_H(20), .ROW_AW(5)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Shape ROM: I, O and T entries used by the vectors; anything else returns a distinctive pattern.
  function automatic logic [15:0] rom(input logic [4:0] a);
    case (a)
      5'd0, 5'd2:             rom = 16'h4444;
      5'd1, 5'd3:             rom = 16'h0F00;
      5'd4, 5'd5, 5'd6, 5'd7: rom = 16'h0660;
      5'd8:                   rom = 16'h04E0;
      default:                rom = 16'h8421;
    endcase
  endfunction

  assign bus.shape_data = rom(bus.shape_addr);

  logic [9:0] board [20];

  always_ff @(posedge Clk) begin
    if (bus.board_rd_en)
      bus.board_row_data <= (bus.board_row_addr < 5'd20) ? board[bus.board_row_addr] : 10'h3FF;
  end

  int n_chk;
  int n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  piece;
    logic [1:0]  rot;
    int          x;
    int          y;
    int          brow;
    logic [9:0]  bval;
    logic        exp_col;
    logic        exp_oob;
    int          exp_rd;
    logic [31:0] exp_rows;
  } vec_t;

  vec_t vecs[14];

  task automatic set_board(input int brow, input logic [9:0] bval);
    for (int i = 0; i < 20; i++) board[i] = 10'h000;
    if (brow >= 0) board[brow] = bval;
  endtask

  task automatic launch(input logic [2:0] p, input logic [1:0] r, input int x, input int y);
    @(negedge Clk);
    bus.piece = p;
    bus.rot   = r;
    bus.pos_x = 5'(x);
    bus.pos_y = 6'(y);
    bus.start = 1'b1;
    @(posedge Clk);
    #1 bus.start = 1'b0;
  endtask

  // Waits for done (bounded), counting read strobes; optionally re-pulses start mid-check.
  task automatic wait_done(input string tag, input int pulse_at, output int lat,
                           output int rdn, output logic [31:0] rows);
    logic got;
    got  = 1'b0;
    lat  = 0;
    rdn  = 0;
    rows = '0;
    while (!got && lat < 20) begin
      @(posedge Clk);
      #1;
      lat++;
      if (lat == 1) chk({tag, "_busy_early"}, 32'(bus.busy), 32'd1);
      if (bus.board_rd_en) begin
        rdn++;
        rows = rows | (32'd1 << bus.board_row_addr);
      end
      if (lat == pulse_at) begin
        bus.piece = 3'd1;
        bus.rot   = 2'd0;
        bus.pos_x = 5'd4;
        bus.pos_y = 6'd0;
        bus.start = 1'b1;
      end
      if (lat == pulse_at + 1) bus.start = 1'b0;
      if (bus.done) got = 1'b1;
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int lat, rdn;
    logic [31:0] rows;
    string tag;
    tag = $sformatf("v%0d", idx);
    set_board(v.brow, v.bval);
    launch(v.piece, v.rot, v.x, v.y);
    wait_done(tag, -10, lat, rdn, rows);
    chk({tag, "_latency"}, 32'(lat), 32'd10);
    chk({tag, "_collide"}, 32'(bus.collide), 32'(v.exp_col));
    chk({tag, "_oob"}, 32'(bus.oob), 32'(v.exp_oob));
    chk({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    chk({tag, "_rd_count"}, 32'(rdn), 32'(v.exp_rd));
    chk({tag, "_rd_rows"}, rows, v.exp_rows);
    chk({tag, "_shape_addr"}, 32'(bus.shape_addr), 32'({v.piece, v.rot}));
    @(posedge Clk);
    #1;
    chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    chk({tag, "_collide_hold"}, 32'(bus.collide), 32'(v.exp_col));
  endtask

  initial begin
    int lat, rdn, extra;
    logic [31:0] rows;
    n_chk  = 0;
    n_fail = 0;

    //          piece rot   x    y  brow  bval    col   oob   rd  rows
    vecs[0]  = '{3'd1, 2'd0,   4,  0, -1, 10'h000, 1'b0, 1'b0, 2, 32'h6};
    vecs[1]  = '{3'd0, 2'd0,  -1,  5, -1, 10'h000, 1'b0, 1'b0, 4, 32'h1E0};
    vecs[2]  = '{3'd0, 2'd0,  -2,  5, -1, 10'h000, 1'b1, 1'b1, 4, 32'h1E0};
    vecs[3]  = '{3'd2, 2'd0,   3, 18, -1, 10'h000, 1'b1, 1'b1, 1, 32'h80000};
    vecs[4]  = '{3'd2, 2'd0,   3,  8, 10, 10'h010, 1'b1, 1'b0, 2, 32'h600};
    vecs[5]  = '{3'd0, 2'd0,   0, -3, -1, 10'h000, 1'b0, 1'b0, 1, 32'h1};
    vecs[6]  = '{3'd0, 2'd1,   7,  0, -1, 10'h000, 1'b1, 1'b1, 1, 32'h2};
    vecs[7]  = '{3'd0, 2'd1,   6,  0, -1, 10'h000, 1'b0, 1'b0, 1, 32'h2};
    vecs[8]  = '{3'd1, 2'd0,   4, 18, -1, 10'h000, 1'b1, 1'b1, 1, 32'h80000};
    vecs[9]  = '{3'd1, 2'd0,   4, -2,  0, 10'h3FF, 1'b1, 1'b0, 1, 32'h1};
    vecs[10] = '{3'd1, 2'd0,  -3, -3, -1, 10'h000, 1'b0, 1'b0, 0, 32'h0};
    vecs[11] = '{3'd0, 2'd0,  15,  0, -1, 10'h000, 1'b1, 1'b1, 4, 32'hF};
    vecs[12] = '{3'd0, 2'd1, -16,  1, -1, 10'h000, 1'b1, 1'b1, 1, 32'h4};
    vecs[13] = '{3'd1, 2'd0,   4,  0,  2, 10'h040, 1'b1, 1'b0, 2, 32'h6};

    Reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.piece = '0;
    bus.rot   = '0;
    bus.pos_x = '0;
    bus.pos_y = '0;
    set_board(-1, 10'h000);
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_collide", 32'(bus.collide), 32'd0);
    chk("rst_oob", 32'(bus.oob), 32'd0);
    chk("rst_rd_en", 32'(bus.board_rd_en), 32'd0);
    chk("rst_shape_addr", 32'(bus.shape_addr), 32'd0);
    chk("rst_row_addr", 32'(bus.board_row_addr), 32'd0);
    Reset_n = 1'b1;
    @(posedge Clk);

    for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

    // Start re-pulsed while busy must not disturb the first check.
    set_board(10, 10'h010);
    launch(3'd2, 2'd0, 3, 8);
    wait_done("repulse", 3, lat, rdn, rows);
    chk("repulse_latency", 32'(lat), 32'd10);
    chk("repulse_collide", 32'(bus.collide), 32'd1);
    chk("repulse_oob", 32'(bus.oob), 32'd0);
    chk("repulse_shape_addr", 32'(bus.shape_addr), 32'd8);
    extra = 0;
    repeat (15) begin
      @(posedge Clk);
      #1;
      if (bus.done || bus.busy) extra++;
    end
    chk("repulse_no_second_check", 32'(extra), 32'd0);
    chk("repulse_collide_hold", 32'(bus.collide), 32'd1);

    // Reset at E+5 aborts the check without a done pulse.
    set_board(-1, 10'h000);
    launch(3'd1, 2'd0, 4, 0);
    repeat (4) @(posedge Clk);
    #1 Reset_n = 1'b0;
    @(posedge Clk);
    #1;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_rd_en", 32'(bus.board_rd_en), 32'd0);
    Reset_n = 1'b1;
    extra = 0;
    repeat (15) begin
      @(posedge Clk);
      #1;
      if (bus.done || bus.busy) extra++;
    end
    chk("midrst_no_done", 32'(extra), 32'd0);
    run_vec(100, vecs[0]);
    run_vec(101, vecs[4]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/piece_collision_check.md
Name: piece_collision_check

Overview:
- Sequential collision checker that sits directly upstream of the tetromino shape ROM.
- For a candidate piece (type, rotation, board position) it drives the ROM address and latches the returned 4x4 shape mask.
- It then scans the four shape rows against the playfield row memory and reports whether the placement is illegal.
- The game control FSM calls it before every move, rotate or drop step.

Parameters:
- BOARD_W, 10, playfield width in cells; board row word width.
- BOARD_H, 20, playfield height in rows; legal rows are 0..BOARD_H-1.
- ROW_AW, 5, board row address width.

Ports:
- Clk  in  1  system clock, all logic on rising edge.
- Reset_n  in  1  synchronous active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- piece  in  3  type 0..6 = I,O,T,J,L,S,Z; values 7 give undefined results.
- rot  in  2  rotation index 0..3.
- pos_x  in  5  signed board column of shape column 0.
- pos_y  in  6  signed board row of shape row 0; negative means above the top.
- shape_addr  out  5  ROM address, equal to {piece_q, rot_q}.
- shape_data  in  16  ROM data, combinational from shape_addr.
- board_rd_en  out  1  board row read strobe.
- board_row_addr  out  ROW_AW  row to read.
- board_row_data  in  BOARD_W  occupancy of the row; bit i = column i. Valid the cycle after board_rd_en.
- busy  out  1  check in progress.
- done  out  1  one-cycle completion pulse.
- collide  out  1  result: placement illegal.
- oob  out  1  result: cause includes a wall or floor violation.

Behaviour:
- Reset (Reset_n low at an edge): go to IDLE. busy, done, collide, oob, board_rd_en all 0. shape_addr 0, board_row_addr 0. Reset mid-check aborts with no done pulse.
- Shape bit mapping: shape[15-4r-c] is row r, column c (r,c = 0..3). Row 0 is the top row; column 0 is leftmost.
- IDLE, start=1: latch piece, rot, pos_x, pos_y; clear collide and oob; busy=1; go to FETCH. start is ignored in every other state.
- FETCH (1 cycle): shape_addr = {piece_q, rot_q}; latch shape_data into shape_q; r=0; go to ROW_REQ.
- ROW_REQ (1 cycle): compute row = pos_y + r as 7-bit signed. Compute col_c = pos_x + c as 6-bit signed; no truncation is allowed.
  - board_rd_en=1, board_row_addr=row only if 0<=row<BOARD_H and row mask nonzero; otherwise board_rd_en=0.
- ROW_CMP (1 cycle): for each set bit c of row r:
  - row<0: ignored (spawn area is legal).
  - row>=BOARD_H, or col_c<0, or col_c>=BOARD_W: set collide and oob (sticky).
  - otherwise board_row_data[col_c]=1: set collide (sticky).
  - r<3: r+1, go to ROW_REQ. r=3: go to DONE.
- DONE (1 cycle): done=1, busy=0, then IDLE.
- Timing: fixed latency, no early exit on the first hit. The start edge is E. FETCH at E+1, the 4 row pairs at E+2..E+9, done high in the cycle after edge E+10.
- busy is high from E+1 through the cycle before done.
- collide and oob hold their value from done until the next accepted start.
- board_rd_en is asserted at most 4 times per check, never outside ROW_REQ.

Test Plan:
- Empty board, piece=1 (O), rot=0, pos=(4,0) -> done exactly 10 edges after start, collide=0, oob=0. board_rd_en pulses twice, for rows 1 and 2.
- I rot0 (0x4444) at pos=(-1,5) -> collide=0. Same piece at pos=(-2,5) -> column -1 gives collide=1, oob=1.
- T rot0 (0x04E0) at pos=(3,18) -> shape row 2 maps to board row 20. Result collide=1, oob=1; no read issued for row 20.
- Board row 10 = 10'b0000010000, T rot0 at pos=(3,8) -> row 2 covers cols 3-5 and hits col 4. Result collide=1, oob=0.
- I rot0 at pos=(0,-3), empty board -> collide=0. board_rd_en asserted exactly once with board_row_addr=0.
- start re-pulsed during busy -> ignored, result of the first check unchanged. Reset_n low at E+5 -> busy=0, no done; a new start then completes normally.
